// File: rtl/pi_bus_xfer_if.sv
// pi_bus_xfer_if
//   Groups the SPI-bridge handshake and the shared-RAM bus signals used by
//   pi_bus_xfer.
//
//   Bridge side : pi_pending, pi_addr[16:0], pi_wr_data[7:0], pi_rw_b,
//                 pi_rd_data[7:0], pi_done
//   Timing gen  : pi_slot
//   RAM bus     : bus_addr[16:0], bus_wr_data[7:0], bus_rd_data[7:0],
//                 bus_rw_b, bus_oe
//   Debug       : state_dbg[1:0]
//
//   Modports
//     master : the surroundings (bridge, timing generator, RAM model).
//     slave  : the pi_bus_xfer block itself.
interface pi_bus_xfer_if;
  logic        pi_pending;
  logic [16:0] pi_addr;
  logic [7:0]  pi_wr_data;
  logic        pi_rw_b;
  logic [7:0]  pi_rd_data;
  logic        pi_done;
  logic        pi_slot;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic [7:0]  bus_rd_data;
  logic        bus_rw_b;
  logic        bus_oe;
  logic [1:0]  state_dbg;

  modport master (
    output pi_pending, pi_addr, pi_wr_data, pi_rw_b, pi_slot, bus_rd_data,
    input  pi_rd_data, pi_done, bus_addr, bus_wr_data, bus_rw_b, bus_oe,
           state_dbg
  );

  modport slave (
    input  pi_pending, pi_addr, pi_wr_data, pi_rw_b, pi_slot, bus_rd_data,
    output pi_rd_data, pi_done, bus_addr, bus_wr_data, bus_rw_b, bus_oe,
           state_dbg
  );
endinterface

// File: rtl/pi_bus_xfer.sv
// pi_bus_xfer
//   Moves one byte between the SPI bridge and the shared RAM bus. A request
//   from the bridge is latched, then waits for a Pi bus window (pi_slot),
//   owns the bus for ACCESS_CYCLES clocks and completes with a four-phase
//   pi_pending / pi_done handshake.
//
//   Parameters
//     ACCESS_CYCLES : clocks the bus is held per access, 1..15.
//   Ports
//     sys_clk : system clock, rising edge.
//     reset   : synchronous, active-high reset.
//     xfer    : pi_bus_xfer_if.slave (bridge handshake, slot strobe,
//               RAM bus, state_dbg).
module pi_bus_xfer #(
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic          sys_clk,
  input  logic          reset,
  pi_bus_xfer_if.slave  xfer
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    ACCESS    = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  // With a multi-cycle write the strobe is released in the last cycle so
  // address/data stay valid one cycle past the write strobe; a single-cycle
  // access has no room for that and keeps the strobe low throughout.
  localparam logic WR_TAIL = (ACCESS_CYCLES > 1);

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  cnt_reg;
  logic [16:0] addr_reg;
  logic [7:0]  wr_data_reg;
  logic        rw_b_reg;
  logic [7:0]  rd_data_reg;
  logic        done_reg;
  logic        bus_oe_c;
  logic        bus_rw_b_c;
  logic        last_access;

  assign last_access = (state_reg == ACCESS) && (cnt_reg == 4'd0);

  // State register
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (xfer.pi_pending) state_next = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        // Withdrawn request aborts without touching the bus.
        if (!xfer.pi_pending)  state_next = IDLE;
        else if (xfer.pi_slot) state_next = ACCESS;
      end
      ACCESS: begin
        // pi_pending is deliberately not looked at: an access always runs
        // to completion once started.
        if (cnt_reg == 4'd0) state_next = DONE;
      end
      DONE: begin
        if (!xfer.pi_pending) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic (bus control depends on state and latched request only)
  always_comb begin
    bus_oe_c   = 1'b0;
    bus_rw_b_c = 1'b1;
    if (state_reg == ACCESS) begin
      bus_oe_c = 1'b1;
      if (!rw_b_reg) begin
        bus_rw_b_c = (cnt_reg == 4'd0) && WR_TAIL;
      end
    end
  end

  // Request latch, access counter, read capture and registered done.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt_reg     <= 4'd0;
      addr_reg    <= 17'd0;
      wr_data_reg <= 8'd0;
      rw_b_reg    <= 1'b1;
      rd_data_reg <= 8'h00;
      done_reg    <= 1'b0;
    end else begin
      // The request is only sampled on IDLE exit, so it cannot move until
      // the handshake has returned to IDLE.
      if (state_reg == IDLE && xfer.pi_pending) begin
        addr_reg    <= xfer.pi_addr;
        wr_data_reg <= xfer.pi_wr_data;
        rw_b_reg    <= xfer.pi_rw_b;
      end

      if (state_reg == WAIT_SLOT && xfer.pi_pending && xfer.pi_slot) begin
        cnt_reg <= CNT_LOAD;
      end else if (state_reg == ACCESS && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      if (last_access && rw_b_reg) begin
        rd_data_reg <= xfer.bus_rd_data;
      end

      // Registered copy of "in DONE next cycle" so pi_done is a flop output
      // that is high exactly while the FSM sits in DONE.
      done_reg <= (state_next == DONE);
    end
  end

  assign xfer.bus_oe      = bus_oe_c;
  assign xfer.bus_rw_b    = bus_rw_b_c;
  assign xfer.bus_addr    = addr_reg;
  assign xfer.bus_wr_data = wr_data_reg;
  assign xfer.pi_rd_data  = rd_data_reg;
  assign xfer.pi_done     = done_reg;
  assign xfer.state_dbg   = state_reg;

endmodule

// File: tb/tb_pi_bus_xfer.sv
module tb_pi_bus_xfer;
  localparam int N = 3;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  pi_bus_xfer_if bus_if ();
  pi_bus_xfer_if bus1 ();

  pi_bus_xfer #(.ACCESS_CYCLES(N)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .xfer    (bus_if.slave)
  );

  pi_bus_xfer #(.ACCESS_CYCLES(1)) dut1 (
    .sys_clk (sys_clk),
    .reset   (reset),
    .xfer    (bus1.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model_rd = 8'h00;  // read data the bridge should currently see

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.pi_pending = 1'b1;   // reset must win over a pending request
    bus_if.pi_slot = 1'b1;
    step();
    step();
    checks++;
    if (bus_if.state_dbg !== 2'd0 || bus_if.pi_done !== 1'b0 || bus_if.bus_oe !== 1'b0 ||
        bus_if.bus_rw_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl got state=%0d done=%b oe=%b rw=%b want 0 0 0 1",
               bus_if.state_dbg, bus_if.pi_done, bus_if.bus_oe, bus_if.bus_rw_b);
    end
    checks++;
    if (bus_if.pi_rd_data !== 8'h00 || bus_if.bus_addr !== 17'd0 || bus_if.bus_wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got rd=%h addr=%h wd=%h want 00 00000 00",
               bus_if.pi_rd_data, bus_if.bus_addr, bus_if.bus_wr_data);
    end
    bus_if.pi_pending = 1'b0;
    bus_if.pi_slot = 1'b0;
    reset = 1'b0;
    step();
    model_rd = 8'h00;
  endtask

  task automatic test_read();
    int oe_cycles;
    int done_at;
    bus_if.pi_addr = 17'h08000;
    bus_if.pi_rw_b = 1'b1;
    bus_if.pi_wr_data = 8'h00;
    bus_if.bus_rd_data = 8'hA5;
    bus_if.pi_pending = 1'b1;
    step();
    checks++;
    if (bus_if.state_dbg !== 2'd1 || bus_if.bus_oe !== 1'b0) begin
      errors++;
      $display("FAIL read_wait got state=%0d oe=%b want 1 0", bus_if.state_dbg, bus_if.bus_oe);
    end
    step();
    bus_if.pi_slot = 1'b1;
    step();
    bus_if.pi_slot = 1'b0;
    oe_cycles = 0;
    done_at = -1;
    for (int k = 1; k <= 10 && done_at < 0; k++) begin
      if (bus_if.bus_oe === 1'b1) begin
        oe_cycles++;
        checks++;
        if (bus_if.bus_addr !== 17'h08000 || bus_if.bus_rw_b !== 1'b1) begin
          errors++;
          $display("FAIL read_bus got addr=%h rw=%b want 08000 1", bus_if.bus_addr, bus_if.bus_rw_b);
        end
      end
      if (bus_if.pi_done === 1'b1) done_at = k;
      else step();
    end
    checks++;
    if (done_at !== N + 1 || oe_cycles !== N) begin
      errors++;
      $display("FAIL read_latency got done_at=%0d oe_cycles=%0d want %0d %0d", done_at, oe_cycles, N + 1, N);
    end
    checks++;
    if (bus_if.pi_rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL read_data got %h want a5", bus_if.pi_rd_data);
    end
    model_rd = 8'hA5;
    bus_if.pi_pending = 1'b0;
    step();
    checks++;
    if (bus_if.pi_done !== 1'b0 || bus_if.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL read_release got done=%b state=%0d want 0 0", bus_if.pi_done, bus_if.state_dbg);
    end
  endtask

  task automatic test_write();
    bus_if.pi_addr = 17'h1FFFF;
    bus_if.pi_wr_data = 8'h3C;
    bus_if.pi_rw_b = 1'b0;
    bus_if.bus_rd_data = 8'h99;
    bus_if.pi_pending = 1'b1;
    step();
    bus_if.pi_slot = 1'b1;
    step();
    bus_if.pi_slot = 1'b0;
    for (int i = 1; i <= N; i++) begin
      checks++;
      if (bus_if.bus_oe !== 1'b1 || bus_if.bus_rw_b !== ((i == N) ? 1'b1 : 1'b0) ||
          bus_if.bus_addr !== 17'h1FFFF || bus_if.bus_wr_data !== 8'h3C) begin
        errors++;
        $display("FAIL write_cycle%0d got oe=%b rw=%b addr=%h wd=%h want 1 %b 1ffff 3c", i,
                 bus_if.bus_oe, bus_if.bus_rw_b, bus_if.bus_addr, bus_if.bus_wr_data, (i == N));
      end
      step();
    end
    checks++;
    if (bus_if.pi_done !== 1'b1 || bus_if.pi_rd_data !== model_rd || bus_if.bus_oe !== 1'b0) begin
      errors++;
      $display("FAIL write_done got done=%b rd=%h oe=%b want 1 %h 0",
               bus_if.pi_done, bus_if.pi_rd_data, bus_if.bus_oe, model_rd);
    end
    bus_if.pi_pending = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int oe_seen = 0;
    int done_seen = 0;
    bus_if.pi_addr = 17'h00F0F;
    bus_if.pi_rw_b = 1'b1;
    bus_if.pi_pending = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus_if.bus_oe === 1'b1) oe_seen++;
      if (bus_if.pi_done === 1'b1) done_seen++;
    end
    bus_if.pi_pending = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus_if.bus_oe === 1'b1) oe_seen++;
      if (bus_if.pi_done === 1'b1) done_seen++;
    end
    checks++;
    if (oe_seen !== 0 || done_seen !== 0 || bus_if.state_dbg !== 2'd0 || bus_if.pi_rd_data !== model_rd) begin
      errors++;
      $display("FAIL abort got oe=%0d done=%0d state=%0d rd=%h want 0 0 0 %h",
               oe_seen, done_seen, bus_if.state_dbg, bus_if.pi_rd_data, model_rd);
    end
  endtask

  task automatic test_slot_ignore();
    int oe_cycles = 0;
    int done_seen = 0;
    bus_if.pi_slot = 1'b1;
    step();
    bus_if.pi_slot = 1'b0;
    checks++;
    if (bus_if.state_dbg !== 2'd0 || bus_if.bus_oe !== 1'b0) begin
      errors++;
      $display("FAIL slot_idle got state=%0d oe=%b want 0 0", bus_if.state_dbg, bus_if.bus_oe);
    end
    bus_if.pi_addr = 17'h00123;
    bus_if.pi_rw_b = 1'b0;
    bus_if.pi_wr_data = 8'h77;
    bus_if.pi_pending = 1'b1;
    step();
    bus_if.pi_slot = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      if (bus_if.bus_oe === 1'b1) oe_cycles++;
      bus_if.pi_slot = (k == 1);
      if (bus_if.pi_done === 1'b1) begin
        done_seen++;
        bus_if.pi_pending = 1'b0;
      end
      step();
    end
    bus_if.pi_slot = 1'b0;
    checks++;
    if (oe_cycles !== N || done_seen !== 1 || bus_if.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL slot_ignore got oe_cycles=%0d done=%0d state=%0d want %0d 1 0",
               oe_cycles, done_seen, bus_if.state_dbg, N);
    end
  endtask

  task automatic test_reset_mid_access();
    bus_if.pi_addr = 17'h04444;
    bus_if.pi_rw_b = 1'b1;
    bus_if.bus_rd_data = 8'hEE;
    bus_if.pi_pending = 1'b1;
    step();
    bus_if.pi_slot = 1'b1;
    step();
    bus_if.pi_slot = 1'b0;
    step();  // second access cycle
    checks++;
    if (bus_if.bus_oe !== 1'b1 || bus_if.state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL rst_mid_pre got oe=%b state=%0d want 1 2", bus_if.bus_oe, bus_if.state_dbg);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_rd = 8'h00;
    checks++;
    if (bus_if.bus_oe !== 1'b0 || bus_if.pi_done !== 1'b0 || bus_if.pi_rd_data !== 8'h00 ||
        bus_if.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid got oe=%b done=%b rd=%h state=%0d want 0 0 00 0",
               bus_if.bus_oe, bus_if.pi_done, bus_if.pi_rd_data, bus_if.state_dbg);
    end
    step();  // pending still held: a fresh transfer must start
    checks++;
    if (bus_if.state_dbg !== 2'd1 || bus_if.bus_addr !== 17'h04444) begin
      errors++;
      $display("FAIL rst_restart got state=%0d addr=%h want 1 04444", bus_if.state_dbg, bus_if.bus_addr);
    end
    bus_if.pi_pending = 1'b0;
    step();
  endtask

  task automatic test_single_cycle();
    bus1.pi_addr = 17'h0ABCD;
    bus1.pi_wr_data = 8'hE1;
    bus1.pi_rw_b = 1'b0;
    bus1.pi_pending = 1'b1;
    step();
    bus1.pi_slot = 1'b1;
    step();
    bus1.pi_slot = 1'b0;
    checks++;
    if (bus1.bus_oe !== 1'b1 || bus1.bus_rw_b !== 1'b0 || bus1.bus_addr !== 17'h0ABCD ||
        bus1.bus_wr_data !== 8'hE1) begin
      errors++;
      $display("FAIL single_write got oe=%b rw=%b addr=%h wd=%h want 1 0 0abcd e1",
               bus1.bus_oe, bus1.bus_rw_b, bus1.bus_addr, bus1.bus_wr_data);
    end
    step();
    checks++;
    if (bus1.pi_done !== 1'b1 || bus1.bus_oe !== 1'b0 || bus1.pi_rd_data !== 8'h00) begin
      errors++;
      $display("FAIL single_wdone got done=%b oe=%b rd=%h want 1 0 00", bus1.pi_done, bus1.bus_oe, bus1.pi_rd_data);
    end
    bus1.pi_pending = 1'b0;
    step();
    bus1.pi_rw_b = 1'b1;
    bus1.bus_rd_data = 8'h5A;
    bus1.pi_pending = 1'b1;
    step();
    bus1.pi_slot = 1'b1;
    step();
    bus1.pi_slot = 1'b0;
    checks++;
    if (bus1.bus_oe !== 1'b1 || bus1.bus_rw_b !== 1'b1) begin
      errors++;
      $display("FAIL single_read got oe=%b rw=%b want 1 1", bus1.bus_oe, bus1.bus_rw_b);
    end
    step();
    checks++;
    if (bus1.pi_done !== 1'b1 || bus1.pi_rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL single_rdone got done=%b rd=%h want 1 5a", bus1.pi_done, bus1.pi_rd_data);
    end
    bus1.pi_pending = 1'b0;
    step();
  endtask

  // Transaction-level model: each transfer waits for its own slot, owns the
  // bus for the N cycles that follow the slot, then sits in DONE until the
  // request is withdrawn. The read byte is whatever the RAM shows in the
  // final bus cycle.
  task automatic test_back_to_back_random(input int count);
    logic [16:0] a;
    logic [7:0]  d;
    logic [7:0]  rd_drive;
    logic        rw;
    logic        exp_rw;
    int          wait_c;
    int          drop_at;
    int          slot_at;
    int          hold;
    for (int t = 0; t < count; t++) begin
      a = 17'($urandom);
      d = 8'($urandom);
      rw = 1'($urandom);
      wait_c = $urandom_range(0, 4);
      drop_at = $urandom_range(0, N + 2);   // >N means pending held through access
      slot_at = $urandom_range(0, N + 2);
      if ($urandom_range(0, 3) == 0) begin
        bus_if.pi_slot = 1'b1;
        step();
        bus_if.pi_slot = 1'b0;
      end
      bus_if.pi_addr = a;
      bus_if.pi_wr_data = d;
      bus_if.pi_rw_b = rw;
      bus_if.pi_pending = 1'b1;
      step();
      for (int w = 0; w <= wait_c; w++) begin
        checks++;
        if (bus_if.state_dbg !== 2'd1 || bus_if.bus_oe !== 1'b0 || bus_if.pi_done !== 1'b0) begin
          errors++;
          $display("FAIL rnd_wait t=%0d got state=%0d oe=%b done=%b want 1 0 0",
                   t, bus_if.state_dbg, bus_if.bus_oe, bus_if.pi_done);
        end
        if (w == wait_c) bus_if.pi_slot = 1'b1;
        step();
      end
      bus_if.pi_slot = 1'b0;
      for (int i = 1; i <= N; i++) begin
        exp_rw = rw ? 1'b1 : ((i == N && N > 1) ? 1'b1 : 1'b0);
        checks++;
        if ({bus_if.state_dbg, bus_if.bus_oe, bus_if.bus_rw_b, bus_if.pi_done} !== {2'd2, 1'b1, exp_rw, 1'b0} ||
            bus_if.bus_addr !== a || bus_if.bus_wr_data !== d) begin
          errors++;
          $display("FAIL rnd_access t=%0d i=%0d got st=%0d oe=%b rw=%b done=%b addr=%h wd=%h want 2 1 %b 0 %h %h",
                   t, i, bus_if.state_dbg, bus_if.bus_oe, bus_if.bus_rw_b, bus_if.pi_done,
                   bus_if.bus_addr, bus_if.bus_wr_data, exp_rw, a, d);
        end
        rd_drive = 8'($urandom);
        bus_if.bus_rd_data = rd_drive;
        if (i == N && rw) model_rd = rd_drive;
        bus_if.pi_slot = (i == slot_at);
        if (i == drop_at) begin
          // Bridge is free to change its request once pending is low.
          bus_if.pi_pending = 1'b0;
          bus_if.pi_addr = 17'($urandom);
          bus_if.pi_wr_data = 8'($urandom);
          bus_if.pi_rw_b = 1'($urandom);
        end
        step();
      end
      bus_if.pi_slot = 1'b0;
      hold = bus_if.pi_pending ? $urandom_range(0, 2) : 0;
      for (int h = 0; h <= hold; h++) begin
        checks++;
        if ({bus_if.state_dbg, bus_if.bus_oe, bus_if.bus_rw_b, bus_if.pi_done} !== {2'd3, 1'b0, 1'b1, 1'b1} ||
            bus_if.pi_rd_data !== model_rd) begin
          errors++;
          $display("FAIL rnd_done t=%0d got st=%0d oe=%b rw=%b done=%b rd=%h want 3 0 1 1 %h",
                   t, bus_if.state_dbg, bus_if.bus_oe, bus_if.bus_rw_b, bus_if.pi_done,
                   bus_if.pi_rd_data, model_rd);
        end
        if (h < hold) begin
          bus_if.pi_slot = 1'($urandom);
          step();
          bus_if.pi_slot = 1'b0;
        end
      end
      bus_if.pi_pending = 1'b0;
      step();
      checks++;
      if ({bus_if.state_dbg, bus_if.bus_oe, bus_if.pi_done} !== {2'd0, 1'b0, 1'b0} ||
          bus_if.pi_rd_data !== model_rd || bus_if.bus_addr !== a || bus_if.bus_wr_data !== d) begin
        errors++;
        $display("FAIL rnd_idle t=%0d got st=%0d oe=%b done=%b rd=%h addr=%h wd=%h want 0 0 0 %h %h %h",
                 t, bus_if.state_dbg, bus_if.bus_oe, bus_if.pi_done, bus_if.pi_rd_data,
                 bus_if.bus_addr, bus_if.bus_wr_data, model_rd, a, d);
      end
    end
  endtask

  initial begin
    bus_if.pi_pending = 1'b0;
    bus_if.pi_addr = 17'd0;
    bus_if.pi_wr_data = 8'd0;
    bus_if.pi_rw_b = 1'b1;
    bus_if.pi_slot = 1'b0;
    bus_if.bus_rd_data = 8'd0;
    bus1.pi_pending = 1'b0;
    bus1.pi_addr = 17'd0;
    bus1.pi_wr_data = 8'd0;
    bus1.pi_rw_b = 1'b1;
    bus1.pi_slot = 1'b0;
    bus1.bus_rd_data = 8'd0;

    test_reset();
    test_read();
    test_write();
    test_abort();
    test_slot_ignore();
    test_reset_mid_access();
    test_single_cycle();
    test_back_to_back_random(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
